piso_serializer: RTL

Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on a single-bit serial line. Frame markers on the first and last bit let a downstream serial-in shift register or deserializer align words. Back-to-back words stream with no idle gap.

---
 rtl/piso_serializer_pkg.sv | 16 +
 rtl/piso_serializer.sv | 82 ++++++++
 2 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in, serial-out transmitter.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } piso_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready load and first/last frame markers.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             data_out,
    output logic             frame,
    output logic             last,
    output logic             busy
);

    localparam int unsigned CW = clog2(WIDTH);

    piso_state_t      state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    count, count_n;
    logic             dout_n, frame_n, last_n;
    logic             accept;

    assign load_ready = (state == ST_IDLE) || (count == '0);
    assign accept     = load_valid && load_ready;
    assign busy       = (state == ST_SHIFT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            count    <= '0;
            data_out <= IDLE_LEVEL;
            frame    <= 1'b0;
            last     <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            count    <= count_n;
            data_out <= dout_n;
            frame    <= frame_n;
            last     <= last_n;
        end
    end

    // The first bit goes straight to data_out, so the register keeps only the
    // remaining bits, already advanced one position toward the send end.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        count_n = count;
        dout_n  = data_out;
        frame_n = frame;
        last_n  = last;
        if (accept) begin
            shreg_n = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
            dout_n  = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
            frame_n = 1'b1;
            last_n  = 1'b0;
            count_n = CW'(WIDTH - 1);
            state_n = ST_SHIFT;
        end else if (state == ST_SHIFT) begin
            if (count != '0) begin
                shreg_n = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
                dout_n  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
                frame_n = 1'b0;
                count_n = count - CW'(1);
                last_n  = (count == CW'(1));
            end else begin
                state_n = ST_IDLE;
                dout_n  = IDLE_LEVEL;
                frame_n = 1'b0;
                last_n  = 1'b0;
            end
        end
    end

endmodule
